pipe_share_arbiter: RTL and testbench

Shares one downstream pipeline between two stream producers. Each producer drives data/valid plus a level flush request. The block does round-robin arbitration into a single registered output stage with valid/ready backpressure. It sequences per-source flushes: stall, discard that source's held word, pulse flush for a fixed count, then acknowledge. It sits between producer FSMs and the shared pipeline input.

---
 rtl/pipe_share_arbiter.sv | 121 ++++++++++++
 tb/tb_pipe_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_share_arbiter.sv
// Two-source round-robin arbiter feeding one registered pipeline stage, with
// per-source flush sequencing (stall, discard held word, pulse flush, acknowledge).
module pipe_share_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [DATA_W-1:0] req_data0,
    input  logic              req_valid0,
    output logic              req_ready0,
    input  logic              flush_req0,

    input  logic [DATA_W-1:0] req_data1,
    input  logic              req_valid1,
    output logic              req_ready1,
    input  logic              flush_req1,

    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,

    output logic              flush_out,
    output logic              flush_src,
    output logic [1:0]        flush_ack
);

    typedef enum logic [1:0] {StRun, StFlush, StAck} state_e;

    localparam logic [7:0] CntInit = 8'(FLUSH_CYCLES - 1);

    state_e     state_q;
    logic       last_grant_q;
    logic [7:0] flush_cnt_q;

    logic load_en;
    logic any_flush;
    logic flush_sel;
    logic run_open;
    logic grant_any;
    logic grant;
    logic accept;

    always_comb begin
        load_en   = !out_valid || out_ready;
        any_flush = flush_req0 || flush_req1;
        // Source 0 wins simultaneous flush requests; the other stays pending.
        flush_sel = !flush_req0;
        run_open  = (state_q == StRun) && !any_flush && load_en;
        grant_any = req_valid0 || req_valid1;
        grant     = (req_valid0 && req_valid1) ? !last_grant_q : req_valid1;
        req_ready0 = run_open && grant_any && !grant;
        req_ready1 = run_open && grant_any && grant;
        accept     = run_open && grant_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRun;
            last_grant_q <= 1'b1;
            flush_cnt_q  <= 8'd0;
            out_data     <= '0;
            out_src      <= 1'b0;
            out_valid    <= 1'b0;
            flush_out    <= 1'b0;
            flush_src    <= 1'b0;
            flush_ack    <= 2'b00;
        end else begin
            flush_ack <= 2'b00;
            // A held word drains on handshake in every state unless replaced below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                StRun: begin
                    if (any_flush) begin
                        state_q     <= StFlush;
                        flush_src   <= flush_sel;
                        flush_out   <= 1'b1;
                        flush_cnt_q <= CntInit;
                        if (out_valid && (out_src == flush_sel)) begin
                            out_valid <= 1'b0;
                        end
                    end else if (accept) begin
                        out_data     <= grant ? req_data1 : req_data0;
                        out_src      <= grant;
                        out_valid    <= 1'b1;
                        last_grant_q <= grant;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == 8'd0) begin
                        flush_out            <= 1'b0;
                        flush_ack[flush_src] <= 1'b1;
                        state_q              <= StAck;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 8'd1;
                    end
                end
                StAck: begin
                    last_grant_q <= flush_src;
                    state_q      <= StRun;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        !(req_ready0 && req_ready1));
    a_no_ready_in_flush: assert property (@(posedge clk) disable iff (reset)
        (state_q != StRun) |-> !(req_ready0 || req_ready1));
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Self-checking bench for pipe_share_arbiter: directed scenarios plus a randomized
// arbitration/backpressure run against a transaction-level reference model.
module tb_pipe_share_arbiter;

    localparam int DW = 32;
    localparam int FC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] req_data0, req_data1;
    logic          req_valid0, req_valid1;
    logic          req_ready0, req_ready1;
    logic          flush_req0, flush_req1;
    logic [DW-1:0] out_data;
    logic          out_src, out_valid, out_ready;
    logic          flush_out, flush_src;
    logic [1:0]    flush_ack;

    int checks = 0;
    int errors = 0;

    pipe_share_arbiter #(.DATA_W(DW), .FLUSH_CYCLES(FC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_data0  (req_data0),
        .req_valid0 (req_valid0),
        .req_ready0 (req_ready0),
        .flush_req0 (flush_req0),
        .req_data1  (req_data1),
        .req_valid1 (req_valid1),
        .req_ready1 (req_ready1),
        .flush_req1 (flush_req1),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush_out  (flush_out),
        .flush_src  (flush_src),
        .flush_ack  (flush_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_data0 = '0;    req_data1 = '0;
        flush_req0 = 1'b0; flush_req1 = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        settle;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL reset_out_src got %b want 0", out_src); end
        checks++; if (flush_out !== 1'b0 || flush_src !== 1'b0) begin errors++; $display("FAIL reset_flush got out=%b src=%b want 0/0", flush_out, flush_src); end
        checks++; if (flush_ack !== 2'b00) begin errors++; $display("FAIL reset_flush_ack got %b want 00", flush_ack); end
        req_valid0 = 1'b1; req_valid1 = 1'b1; out_ready = 1'b1;
        settle;
        checks++; if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin errors++; $display("FAIL reset_first_grant got r0=%b r1=%b want 1/0", req_ready0, req_ready1); end
    endtask

    task automatic test_single_source;
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            req_valid0 = 1'b1; req_data0 = DW'(i);
            settle;
            checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL single_ready0 i=%0d got %b want 1", i, req_ready0); end
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got out_valid=%b want 0", out_valid); end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== DW'(i - 1) || out_src !== 1'b0) begin
                    errors++; $display("FAIL single_data i=%0d got v=%b d=%h s=%b want 1/%h/0", i, out_valid, out_data, out_src, DW'(i - 1));
                end
            end
            tick;
        end
        req_valid0 = 1'b0;
        settle;
        checks++; if (out_valid !== 1'b1 || out_data !== DW'(8)) begin errors++; $display("FAIL single_last got v=%b d=%h want 1/8", out_valid, out_data); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_round_robin;
        int n0, n1;
        logic [DW-1:0] exp_d;
        bit e0;
        do_reset;
        out_ready = 1'b1;
        n0 = 0; n1 = 0;
        for (int j = 0; j < 8; j++) begin
            req_valid0 = 1'b1; req_valid1 = 1'b1;
            req_data0 = DW'(32'hA0 + n0); req_data1 = DW'(32'hB0 + n1);
            settle;
            e0 = (j % 2 == 0);
            checks++; if (req_ready0 !== e0 || req_ready1 !== !e0) begin errors++; $display("FAIL rr_ready j=%0d got r0=%b r1=%b want %b/%b", j, req_ready0, req_ready1, e0, !e0); end
            if (e0) begin exp_d = DW'(32'hA0 + n0); n0++; end
            else begin exp_d = DW'(32'hB0 + n1); n1++; end
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_src !== !e0 || out_data !== exp_d) begin
                errors++; $display("FAIL rr_out j=%0d got v=%b s=%b d=%h want 1/%b/%h", j, out_valid, out_src, out_data, !e0, exp_d);
            end
        end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        out_ready = 1'b0;
        req_valid0 = 1'b1; req_data0 = DW'(5);
        settle;
        checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL bp_load got r0=%b want 1", req_ready0); end
        tick;
        req_data0 = DW'(32'h10); req_valid1 = 1'b1; req_data1 = DW'(32'h20);
        for (int k = 0; k < 3; k++) begin
            settle;
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(5) || req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin
                errors++; $display("FAIL bp_hold k=%0d got v=%b d=%h r0=%b r1=%b want 1/5/0/0", k, out_valid, out_data, req_ready0, req_ready1);
            end
            tick;
        end
        out_ready = 1'b1;
        settle;
        checks++; if (req_ready1 !== 1'b1 || req_ready0 !== 1'b0) begin errors++; $display("FAIL bp_release got r0=%b r1=%b want 0/1", req_ready0, req_ready1); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== DW'(32'h20) || out_src !== 1'b1) begin errors++; $display("FAIL bp_next got v=%b d=%h s=%b want 1/20/1", out_valid, out_data, out_src); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== DW'(32'h10) || out_src !== 1'b0) begin errors++; $display("FAIL bp_after got v=%b d=%h s=%b want 1/10/0", out_valid, out_data, out_src); end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick;
    endtask

    task automatic test_flush_src1;
        do_reset;
        out_ready = 1'b0;
        req_valid1 = 1'b1; req_data1 = DW'(32'h77);
        settle;
        tick;
        req_valid1 = 1'b0; req_valid0 = 1'b1; flush_req1 = 1'b1;
        settle;
        checks++; if (out_valid !== 1'b1 || req_ready0 !== 1'b0) begin errors++; $display("FAIL fl1_stall got v=%b r0=%b want 1/0", out_valid, req_ready0); end
        tick;
        for (int k = 0; k < FC; k++) begin
            settle;
            checks++;
            if (flush_out !== 1'b1 || flush_src !== 1'b1 || flush_ack !== 2'b00 || out_valid !== 1'b0 || req_ready0 !== 1'b0) begin
                errors++; $display("FAIL fl1_active k=%0d got fo=%b fs=%b ack=%b v=%b r0=%b want 1/1/00/0/0", k, flush_out, flush_src, flush_ack, out_valid, req_ready0);
            end
            tick;
        end
        checks++; if (flush_out !== 1'b0 || flush_ack !== 2'b10) begin errors++; $display("FAIL fl1_ack got fo=%b ack=%b want 0/10", flush_out, flush_ack); end
        flush_req1 = 1'b0; req_valid1 = 1'b1; out_ready = 1'b1;
        settle;
        checks++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin errors++; $display("FAIL fl1_ack_stall got r0=%b r1=%b want 0/0", req_ready0, req_ready1); end
        tick;
        checks++; if (flush_ack !== 2'b00) begin errors++; $display("FAIL fl1_ack_pulse got %b want 00", flush_ack); end
        checks++; if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin errors++; $display("FAIL fl1_next_grant got r0=%b r1=%b want 1/0", req_ready0, req_ready1); end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick;
    endtask

    task automatic test_dual_flush;
        do_reset;
        out_ready = 1'b1;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        req_data0 = DW'(32'h1); req_data1 = DW'(32'h2);
        flush_req0 = 1'b1; flush_req1 = 1'b1;
        settle;
        checks++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin errors++; $display("FAIL dual_start got r0=%b r1=%b want 0/0", req_ready0, req_ready1); end
        tick;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < FC; k++) begin
                settle;
                checks++;
                if (flush_out !== 1'b1 || flush_src !== 1'(s) || req_ready0 !== 1'b0 || req_ready1 !== 1'b0 || out_valid !== 1'b0) begin
                    errors++; $display("FAIL dual_active s=%0d k=%0d got fo=%b fs=%b r0=%b r1=%b v=%b want 1/%0d/0/0/0", s, k, flush_out, flush_src, req_ready0, req_ready1, out_valid, s);
                end
                tick;
            end
            checks++;
            if (flush_ack !== ((s == 0) ? 2'b01 : 2'b10) || flush_out !== 1'b0) begin
                errors++; $display("FAIL dual_ack s=%0d got ack=%b fo=%b want %b/0", s, flush_ack, flush_out, (s == 0) ? 2'b01 : 2'b10);
            end
            if (s == 0) flush_req0 = 1'b0; else flush_req1 = 1'b0;
            tick;
            checks++; if (flush_ack !== 2'b00 || flush_out !== 1'b0) begin errors++; $display("FAIL dual_run s=%0d got ack=%b fo=%b want 00/0", s, flush_ack, flush_out); end
            if (s == 0) begin
                checks++; if (req_ready0 !== 1'b0 || req_ready1 !== 1'b0) begin errors++; $display("FAIL dual_gap got r0=%b r1=%b want 0/0", req_ready0, req_ready1); end
                tick;
            end else begin
                checks++; if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin errors++; $display("FAIL dual_resume got r0=%b r1=%b want 1/0", req_ready0, req_ready1); end
            end
        end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_flush;
        do_reset;
        out_ready = 1'b0;
        req_valid1 = 1'b1; req_data1 = DW'(32'h99);
        tick;
        req_valid1 = 1'b0; flush_req0 = 1'b1;
        tick;
        checks++; if (flush_out !== 1'b1 || flush_src !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rmf_other_held got fo=%b fs=%b v=%b want 1/0/1", flush_out, flush_src, out_valid); end
        tick;
        reset = 1'b1; flush_req0 = 1'b0;
        tick;
        checks++; if (flush_out !== 1'b0 || flush_ack !== 2'b00 || out_valid !== 1'b0) begin errors++; $display("FAIL rmf_abort got fo=%b ack=%b v=%b want 0/00/0", flush_out, flush_ack, out_valid); end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle;
            checks++; if (flush_ack !== 2'b00 || flush_out !== 1'b0) begin errors++; $display("FAIL rmf_no_ack k=%0d got ack=%b fo=%b want 00/0", k, flush_ack, flush_out); end
            tick;
        end
        req_valid0 = 1'b1; req_valid1 = 1'b1; out_ready = 1'b1;
        settle;
        checks++; if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin errors++; $display("FAIL rmf_first_grant got r0=%b r1=%b want 1/0", req_ready0, req_ready1); end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick;
    endtask

    // Reference: the stage holds at most one word; a free slot (or one being
    // drained) is offered to the single valid source, or alternately when both are valid.
    task automatic test_random;
        logic [DW:0]   sb[$];
        logic [DW:0]   got;
        logic [DW:0]   want;
        bit            m_full, m_last, free, both, pick, e0, e1;
        do_reset;
        m_full = 1'b0; m_last = 1'b1;
        for (int c = 0; c < 400; c++) begin
            req_valid0 = 1'($urandom_range(0, 1));
            req_valid1 = 1'($urandom_range(0, 1));
            req_data0 = DW'($urandom);
            req_data1 = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            settle;
            free = !m_full || out_ready;
            both = req_valid0 && req_valid1;
            pick = both ? !m_last : req_valid1;
            e0 = free && req_valid0 && (both ? !pick : 1'b1);
            e1 = free && req_valid1 && (both ? pick : 1'b1);
            checks++; if (req_ready0 !== e0 || req_ready1 !== e1) begin errors++; $display("FAIL rand_ready c=%0d got r0=%b r1=%b want %b/%b", c, req_ready0, req_ready1, e0, e1); end
            checks++; if (out_valid !== m_full) begin errors++; $display("FAIL rand_valid c=%0d got %b want %b", c, out_valid, m_full); end
            if (m_full && out_ready) begin
                got = {out_src, out_data};
                want = (sb.size() > 0) ? sb.pop_front() : '1;
                checks++; if (got !== want) begin errors++; $display("FAIL rand_word c=%0d got %h want %h", c, got, want); end
                m_full = 1'b0;
            end
            if (e0 || e1) begin
                sb.push_back(e1 ? {1'b1, req_data1} : {1'b0, req_data0});
                m_full = 1'b1;
                m_last = e1;
            end
            tick;
        end
        checks++; if (sb.size() != (m_full ? 1 : 0)) begin errors++; $display("FAIL rand_residue got %0d want %0d", sb.size(), m_full ? 1 : 0); end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_source;
        test_round_robin;
        test_backpressure;
        test_flush_src1;
        test_dual_flush;
        test_reset_mid_flush;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
